// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// state encoding, opcode/funct constants and ALU control encodings.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_ctrl_dec.sv
// R-type funct decoder.
// Ports: funct (instruction[5:0]) in; alu_ctrl (ALU operation) and
// valid (funct is a supported R-type operation) out, both combinational.
module alu_ctrl_dec
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]   funct,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              valid
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit (lw, sw, R-type, beq, addi).
// Ports: clk, reset (async, active-high); Op/Function/Zero from the
// datapath; datapath mux selects and write enables; illegal (one-cycle
// pulse in DECODE for unsupported instructions); instr_count (retired
// instructions, wraps); state (debug view of the state register).
// Controls are decoded from the state register; PCSel in BRANCH follows
// Zero and ALUCtrl in EXEC follows Function.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic [OP_W-1:0]    Function,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               PCSource,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               PCSel,
  output logic [1:0]         ALUSrcB,
  output logic [ALUC_W-1:0]  ALUCtrl,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count,
  output logic [STATE_W-1:0] state
);

  state_t              state_q;
  state_t              state_d;
  logic                is_load_q;
  logic                retire;
  logic [ALUC_W-1:0]   dec_alu;
  logic                dec_valid;

  alu_ctrl_dec u_alu_ctrl_dec (
    .funct    (Function),
    .alu_ctrl (dec_alu),
    .valid    (dec_valid)
  );

  assign state = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Load/store direction is captured in DECODE so MEMADR does not re-read Op
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      is_load_q <= 1'b0;
    else if (state_q == S_DECODE)   is_load_q <= (Op == OP_LW);
  end

  // Every terminal state returns to FETCH and retires its instruction
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_ADDI_WB: retire = 1'b1;
      default:                                      retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    IRWrite  = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    PCSel    = 1'b0;
    ALUSrcB  = 2'b00;
    ALUCtrl  = ALU_ADD;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCSel   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        if (Op == OP_RTYPE && dec_valid)      state_d = S_EXEC;
        else if (Op == OP_LW || Op == OP_SW)  state_d = S_MEMADR;
        else if (Op == OP_BEQ)                state_d = S_BRANCH;
        else if (Op == OP_ADDI)               state_d = S_ADDI_EX;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_load_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = dec_alu;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = ALU_SUB;
        PCSource = 1'b1;
        PCSel    = Zero;
        state_d  = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The register resets to FETCH; keep its enables quiet while reset is held
    if (reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCSel    = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: the driver expands each
// instruction into its expected per-cycle control vectors from the
// instruction-level behaviour, a monitor pops one vector per clock.
// A second instance with a 3-bit counter exercises counter wrap.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0]  st;
    logic        iord, mrd, mwr, m2r, irw, pcsrc, srca, rw, rdst, pcsel;
    logic [1:0]  srcb;
    logic [3:0]  aluc;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Op = '0, Function = '0;
  logic Zero = 1'b0;

  logic IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, RegWrite, RegDst, PCSel;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUCtrl;
  logic illegal;
  logic [15:0] instr_count;
  logic [3:0] state;

  logic s_iord, s_mrd, s_mwr, s_m2r, s_irw, s_pcsrc, s_srca, s_rw, s_rdst, s_pcsel;
  logic [1:0] s_srcb;
  logic [3:0] s_aluc;
  logic s_ill;
  logic [2:0] s_cnt;
  logic [3:0] s_state;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  bit mon_en = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSel(PCSel), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(s_iord), .MemRead(s_mrd), .MemWrite(s_mwr), .MemtoReg(s_m2r),
    .IRWrite(s_irw), .PCSource(s_pcsrc), .ALUSrcA(s_srca), .RegWrite(s_rw),
    .RegDst(s_rdst), .PCSel(s_pcsel), .ALUSrcB(s_srcb), .ALUCtrl(s_aluc),
    .illegal(s_ill), .instr_count(s_cnt), .state(s_state)
  );

  // Supported R-type functs and their ALU operation
  function automatic bit rtype_ok(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h27 || fn == 6'h2A;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h27:   return 4'b1100;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return rtype_ok(fn);
    return op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08;
  endfunction

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.aluc = 4'b0010;
    e.cnt = 16'(model_cnt);
    return e;
  endfunction

  // Expand one instruction into its cycle-by-cycle expectations; keep<0 runs it fully
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int keep);
    exp_t e;
    exp_t q[$];
    Op = op; Function = fn; Zero = z;
    e = base(4'd0); e.mrd = 1; e.irw = 1; e.srcb = 2'b01; e.pcsel = 1; q.push_back(e);
    e = base(4'd1); e.srcb = 2'b10; e.ill = !legal(op, fn); q.push_back(e);
    if (legal(op, fn)) begin
      case (op)
        6'h23, 6'h2B: begin
          e = base(4'd2); e.srca = 1; e.srcb = 2'b10; q.push_back(e);
          if (op == 6'h23) begin
            e = base(4'd3); e.iord = 1; e.mrd = 1; q.push_back(e);
            e = base(4'd4); e.rw = 1; e.m2r = 1; q.push_back(e);
          end else begin
            e = base(4'd5); e.iord = 1; e.mwr = 1; q.push_back(e);
          end
        end
        6'h00: begin
          e = base(4'd6); e.srca = 1; e.aluc = alu_of(fn); q.push_back(e);
          e = base(4'd7); e.rw = 1; e.rdst = 1; q.push_back(e);
        end
        6'h04: begin
          e = base(4'd8); e.srca = 1; e.aluc = 4'b0110; e.pcsrc = 1; e.pcsel = z; q.push_back(e);
        end
        default: begin
          e = base(4'd9); e.srca = 1; e.srcb = 2'b10; q.push_back(e);
          e = base(4'd10); e.rw = 1; q.push_back(e);
        end
      endcase
    end
    if (keep >= 0) while (q.size() > keep) void'(q.pop_back());
    foreach (q[i]) sb.push_back(q[i]);
    repeat (q.size()) @(posedge clk);
    #1;
    if (keep < 0 && legal(op, fn)) model_cnt++;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: one expected vector per clock while running
  always @(negedge clk) begin
    exp_t e, a;
    if (mon_en && !reset) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow got=state%0d want=queued_entry", state);
      end else begin
        e = sb.pop_front();
        a.st = state; a.iord = IorD; a.mrd = MemRead; a.mwr = MemWrite; a.m2r = MemtoReg;
        a.irw = IRWrite; a.pcsrc = PCSource; a.srca = ALUSrcA; a.rw = RegWrite;
        a.rdst = RegDst; a.pcsel = PCSel; a.srcb = ALUSrcB; a.aluc = ALUCtrl;
        a.ill = illegal; a.cnt = instr_count;
        if (a.srcb[1]) a.srcb[0] = 1'b0;  // 1x means sign-extended immediate
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl_vec t=%0t got=%h want=%h", $time, a, e);
        end
        checks++;
        if (s_cnt !== e.cnt[2:0]) begin
          errors++;
          $display("FAIL wrap_cnt t=%0t got=%0d want=%0d", $time, s_cnt, e.cnt[2:0]);
        end
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    int cls;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_count", instr_count, 16'd0);
    chk("reset_illegal", 16'(illegal), 16'd0);
    chk("reset_enables", 16'({MemRead, MemWrite, IRWrite, PCSel, RegWrite}), 16'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(6'h23, 6'h00, 1'b0, -1);  // lw
    issue(6'h00, 6'h22, 1'b0, -1);  // sub
    issue(6'h04, 6'h00, 1'b1, -1);  // beq taken
    issue(6'h04, 6'h00, 1'b0, -1);  // beq not taken
    issue(6'h3F, 6'h20, 1'b0, -1);  // illegal op
    issue(6'h00, 6'h01, 1'b1, -1);  // illegal funct
    issue(6'h08, 6'h00, 1'b0, -1);  // addi
    chk("count_directed", instr_count, 16'd5);

    // Abort a store in MEMWR with an asynchronous reset
    issue(6'h2B, 6'h00, 1'b0, 3);
    mon_en = 1'b0;
    chk("memwr_before_reset", 16'(MemWrite), 16'd1);
    reset = 1'b1;
    #1;
    chk("memwr_async_drop", 16'(MemWrite), 16'd0);
    chk("abort_state", 16'(state), 16'd0);
    chk("abort_count", instr_count, 16'd0);
    chk("abort_wrap_count", 16'(s_cnt), 16'd0);
    @(posedge clk);
    #1;
    chk("reset_held_enables", 16'({MemRead, MemWrite, IRWrite, PCSel, RegWrite}), 16'd0);
    model_cnt = 0;
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 200; i++) begin
      cls = int'($urandom_range(0, 5));
      fn = 6'($urandom);
      case (cls)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin
          op = 6'h00;
          case ($urandom_range(0, 5))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
            3: fn = 6'h25; 4: fn = 6'h27; default: fn = 6'h2A;
          endcase
        end
        3: op = 6'h04;
        4: op = 6'h08;
        default: begin
          op = 6'($urandom);
          while (legal(op, fn)) begin
            op = 6'($urandom);
            fn = 6'($urandom);
          end
        end
      endcase
      issue(op, fn, 1'($urandom), -1);
    end

    chk("count_final", instr_count, 16'(model_cnt));
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

- Multicycle MIPS-subset control unit.
- Sequences the shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps, one state per clock.
- Consumes the datapath's Op, Function and Zero; drives every datapath mux select and write enable.
- Adds an illegal-instruction pulse and a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- Op  in  6  instruction[31:26]
- Function  in  6  instruction[5:0]
- Zero  in  1  ALU result == 0
- IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource, ALUSrcA, RegWrite, RegDst, PCSel  out  1 each  datapath controls
- ALUSrcB  out  2  00 = B, 01 = constant 1, 1x = sign-extended imm16
- ALUCtrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- illegal  out  1  one-cycle pulse on an unsupported Op/Function
- instr_count  out  CNT_W  retired instructions, wraps
- state  out  4  current state, for debug

## Operation
- Default for every output not listed below: 0. ALUCtrl default is 0010.
- States:
  - FETCH: MemRead, IRWrite, ALUSrcB=01, PCSel (PCSource=0, so PC <= PC+1). Next: DECODE.
  - DECODE: ALUSrcB=1x, so ALUOut <= PC+imm (branch target).
    - Op 0x00 with Function in {20,22,24,25,27,2A}: EXEC.
    - Op 0x23 or 0x2B: MEMADR.
    - Op 0x04: BRANCH.
    - Op 0x08: ADDI_EX.
    - Anything else: illegal=1, next FETCH; the instruction is not retired.
  - MEMADR: ALUSrcA=1, ALUSrcB=1x. Next: MEMRD for 0x23, MEMWR for 0x2B.
  - MEMRD: IorD, MemRead (mdr captures). Next: MEMWB.
  - MEMWB: RegWrite, MemtoReg, RegDst=0. Next: FETCH.
  - MEMWR: IorD, MemWrite. Next: FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtrl from Function (20→0010, 22→0110, 24→0000, 25→0001, 27→1100, 2A→0111). Next: RWB.
  - RWB: RegWrite, RegDst=1, MemtoReg=0. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=0110, PCSource=1, PCSel=Zero. Next: FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=1x, ALUCtrl=0010. Next: ADDI_WB.
  - ADDI_WB: RegWrite, RegDst=0. Next: FETCH.
- Op and Function are sampled only in DECODE and EXEC. The instruction register is stable then because IRWrite is asserted only in FETCH.
- instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or ADDI_WB, and wraps from all-ones to 0.

## Timing
- Reset values: state = FETCH (0), instr_count = 0, illegal = 0.
- While reset is high, MemRead, MemWrite, IRWrite, PCSel and RegWrite are forced to 0. The first FETCH is the cycle after deassertion.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted in the reset cycle and the count is not incremented.
- All outputs are combinational from state (Moore), except:
  - PCSel in BRANCH, which follows Zero in the same cycle (Mealy).
  - ALUCtrl in EXEC, which decodes Function.
- Latency per instruction, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3 (taken or not), illegal 2.
- Outputs must be glitch-free relative to the clock edge. The datapath samples them only at posedge.

## Structure
- Package `mc_pkg`:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - funct constants
  - ALUCtrl encodings
- Sub-module `alu_ctrl_dec`: maps Function to {ALUCtrl, valid}. It is used in EXEC and for the legality check in DECODE.
- Top level holds the state register, the next-state logic, the output decode and the counter.

## Test plan
- Reset asserted mid-MEMWR → MemWrite drops to 0 asynchronously; after release, state=FETCH and instr_count=0.
- lw (Op=0x23) → states 0,1,2,3,4; MemRead high in FETCH and MEMRD; RegWrite+MemtoReg only in MEMWB; instr_count +1.
- R-type sub (Function=0x22) → ALUCtrl=0110 in EXEC; RegWrite+RegDst in RWB; 4 cycles total.
- beq with Zero=1, then again with Zero=0 → PCSel=1 with PCSource=1 in BRANCH for the first, PCSel=0 for the second; both take 3 cycles and count.
- Op=0x3F, then Op=0 with Function=0x01 → illegal pulses for exactly one cycle in DECODE; next state FETCH; instr_count unchanged.
- Preload instr_count to 0xFFFF (CNT_W=16), retire one addi → count reads 0x0000.
